// File: rtl/io_map_pkg.sv
// Shared definitions for the memory/IO bridge: I/O register offsets (address[3:2]),
// UART status bit positions and the UART transmitter state encoding.
package io_map_pkg;

  // I/O register select, taken from address[3:2]
  localparam logic [1:0] IO_LEDS        = 2'd0;
  localparam logic [1:0] IO_UART_DATA   = 2'd1;
  localparam logic [1:0] IO_UART_STATUS = 2'd2;
  localparam logic [1:0] IO_RESERVED    = 2'd3;

  // UART status register bit positions
  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_OVERRUN = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first. A start pulse while idle latches the byte and
// begins the frame on that same edge; start is ignored while busy.
// Every bit (start, 8 data, stop) is held for exactly BAUD_DIV clock cycles.
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous active-low reset; aborts any frame, TXD returns high
//   start  - launch request, honoured only when idle
//   data   - byte to transmit
//   busy   - high from the accepting edge until the stop bit has completed
//   TXD    - serial line, idles high
module uart_tx
  import io_map_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       TXD
);

  localparam int unsigned     CntW     = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudLoad = CntW'(BAUD_DIV - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            baud_tick;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign baud_tick = (baud_q == '0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStart;
          baud_d  = BaudLoad;
          bit_d   = '0;
          shift_d = data;
        end
      end
      StStart: begin
        if (baud_tick) begin
          state_d = StData;
          baud_d  = BaudLoad;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d  = BaudLoad;
          shift_d = shift_q >> 1;
          // Counter wraps 7 -> 0 as the last data bit ends
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_tick) begin
          state_d = StIdle;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state so reset forces TXD high without waiting for a clock
  always_comb begin
    busy = (state_q != StIdle);
    TXD  = 1'b1;
    case (state_q)
      StStart: TXD = 1'b0;
      StData:  TXD = shift_q[0];
      default: TXD = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_io_bridge.sv
// Bus bridge between the core and program memory. address[IO_BIT] splits the space
// into RAM (0) and I/O (1); inside I/O only address[3:2] is decoded:
//   0x0 LEDS (r/w, byte lanes), 0x4 UART data (w), 0x8 UART status (r), 0xC reserved.
// Read data comes back one cycle after the read strobe for both spaces.
// Build option: define MEMORY_IO_UART_EN to include the UART transmitter and its status
// register; without it TXD is tied high and offsets 0x4/0x8 read 0 and ignore writes.
// Ports:
//   CLK, RESET              - clock and asynchronous active-low reset
//   address, writeData      - core bus address and store data
//   writeMask, read         - core byte-lane write enables and read strobe
//   memReadData             - registered read data from program memory
//   memWriteMask            - write mask forwarded to program memory (0 for I/O)
//   readData                - read data returned to the core
//   LEDS                    - LED register
//   TXD                     - UART serial output
module memory_io_bridge
  import io_map_pkg::*;
#(
  parameter int unsigned IO_BIT   = 22,
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [3:0]  writeMask,
  input  logic        read,
  input  logic [31:0] memReadData,
  output logic [3:0]  memWriteMask,
  output logic [31:0] readData,
  output logic [31:0] LEDS,
  output logic        TXD
);

  logic        io_sel;
  logic [1:0]  io_off;
  logic        io_wr;
  logic        led_we;
  logic [31:0] leds_q, leds_d;
  logic [31:0] status_val;
  logic [31:0] io_rd_val;
  logic        io_sel_q, io_sel_d;
  logic [31:0] io_data_q, io_data_d;
  logic        unused_addr;

  assign io_sel       = address[IO_BIT];
  assign io_off       = address[3:2];
  assign io_wr        = io_sel & (|writeMask);
  assign led_we       = io_wr & (io_off == IO_LEDS);
  assign memWriteMask = io_sel ? 4'b0000 : writeMask;
  // Only the select bit and address[3:2] are decoded
  assign unused_addr  = ^address;

`ifdef MEMORY_IO_UART_EN
  logic uart_wr;
  logic uart_busy;
  logic status_rd;
  logic overrun_q, overrun_d;

  assign uart_wr   = io_wr & (io_off == IO_UART_DATA);
  assign status_rd = read & io_sel & (io_off == IO_UART_STATUS);

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .CLK  (CLK),
    .RESET(RESET),
    .start(uart_wr & ~uart_busy),
    .data (writeData[7:0]),
    .busy (uart_busy),
    .TXD  (TXD)
  );

  // Sticky overrun: a write while busy sets it, a status read clears it, set wins
  always_comb begin
    overrun_d = overrun_q;
    if (status_rd) begin
      overrun_d = 1'b0;
    end
    if (uart_wr && uart_busy) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    status_val                 = '0;
    status_val[STATUS_BUSY]    = uart_busy;
    status_val[STATUS_OVERRUN] = overrun_q;
  end
`else
  assign TXD        = 1'b1;
  assign status_val = '0;
`endif

  // LED register with per-lane write enables
  always_comb begin
    leds_d = leds_q;
    for (int b = 0; b < 4; b++) begin
      if (led_we && writeMask[b]) begin
        leds_d[8*b +: 8] = writeData[8*b +: 8];
      end
    end
  end

  always_comb begin
    case (io_off)
      IO_LEDS:        io_rd_val = leds_q;
      IO_UART_STATUS: io_rd_val = status_val;
      default:        io_rd_val = '0;
    endcase
  end

  // Read capture holds its value while read is low
  always_comb begin
    io_sel_d  = io_sel_q;
    io_data_d = io_data_q;
    if (read) begin
      io_sel_d  = io_sel;
      io_data_d = io_rd_val;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      leds_q    <= '0;
      io_sel_q  <= 1'b0;
      io_data_q <= '0;
    end else begin
      leds_q    <= leds_d;
      io_sel_q  <= io_sel_d;
      io_data_q <= io_data_d;
    end
  end

  assign LEDS     = leds_q;
  assign readData = io_sel_q ? io_data_q : memReadData;

endmodule

// File: tb/tb_memory_io_bridge.sv
// Self-checking bench for memory_io_bridge: a cycle-level behavioural model (frame start
// time + byte, LED value, overrun flag, captured read) is compared against the DUT on
// every falling edge, plus directed checks with hand-computed literal values.
module tb_memory_io_bridge;

  localparam int unsigned IoBit   = 22;
  localparam int unsigned BaudDiv = 4;
`ifdef MEMORY_IO_UART_EN
  localparam bit UartEn = 1'b1;
`else
  localparam bit UartEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [3:0]  writeMask = '0;
  logic        read = 1'b0;
  logic [31:0] memReadData = '0;
  logic [3:0]  memWriteMask;
  logic [31:0] readData;
  logic [31:0] LEDS;
  logic        TXD;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_io_bridge #(
    .IO_BIT  (IoBit),
    .BAUD_DIV(BaudDiv)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .address     (address),
    .writeData   (writeData),
    .writeMask   (writeMask),
    .read        (read),
    .memReadData (memReadData),
    .memWriteMask(memWriteMask),
    .readData    (readData),
    .LEDS        (LEDS),
    .TXD         (TXD)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_leds;
  logic        m_rsel;
  logic [31:0] m_rdata;
  logic        m_ovr;
  bit          m_active;
  longint      m_cyc;
  longint      m_fs;
  logic [7:0]  m_byte;
  logic        m_pre_busy;
  logic        m_set_ovr;
  logic        m_sel;
  logic [1:0]  m_off;

  // Busy after the most recent edge: a frame lasts 10 bit times from its start edge
  function automatic logic m_busy();
    return m_active && ((m_cyc - m_fs) < longint'(10 * BaudDiv));
  endfunction

  function automatic logic m_txd();
    longint k;
    if (!m_busy()) return 1'b1;
    k = (m_cyc - m_fs) / longint'(BaudDiv);
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[int'(k) - 1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_leds   = '0;
      m_rsel   = 1'b0;
      m_rdata  = '0;
      m_ovr    = 1'b0;
      m_active = 1'b0;
      m_cyc    = 0;
      m_fs     = 0;
      m_byte   = '0;
    end else begin
      m_pre_busy = m_busy();
      m_sel      = address[IoBit];
      m_off      = address[3:2];
      m_set_ovr  = 1'b0;
      if (read) begin
        m_rsel = m_sel;
        if (m_off == 2'd0) m_rdata = m_leds;
        else if (m_off == 2'd2 && UartEn) m_rdata = {30'b0, m_ovr, m_pre_busy};
        else m_rdata = '0;
      end
      if (m_sel && writeMask != 4'b0) begin
        if (m_off == 2'd0) begin
          for (int b = 0; b < 4; b++)
            if (writeMask[b]) m_leds[8*b +: 8] = writeData[8*b +: 8];
        end else if (m_off == 2'd1 && UartEn) begin
          if (m_pre_busy) begin
            m_set_ovr = 1'b1;
          end else begin
            m_active = 1'b1;
            m_fs     = m_cyc + 1;
            m_byte   = writeData[7:0];
          end
        end
      end
      if (read && m_sel && m_off == 2'd2) m_ovr = 1'b0;
      if (m_set_ovr) m_ovr = 1'b1;
      m_cyc = m_cyc + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("readData", readData, m_rsel ? m_rdata : memReadData);
      check("LEDS", LEDS, m_leds);
      check("TXD", 32'(TXD), 32'(m_txd()));
      check("memWriteMask", 32'(memWriteMask), address[IoBit] ? 32'h0 : 32'(writeMask));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic rd);
    address     = a;
    writeData   = wd;
    writeMask   = m;
    read        = rd;
    memReadData = $urandom;
  endtask

  task automatic idle();
    set_in(32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    int          r;
`ifdef MEMORY_IO_UART_EN
    bit pat [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    idle();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    #1;
    check("reset_leds", LEDS, 32'h0);
    check("reset_txd", 32'(TXD), 32'h1);

    // RAM passthrough
    set_in(32'h190, $urandom, 4'b0010, 1'b0);
    #1 check("ram_wmask", 32'(memWriteMask), 32'h2);
    step();
    set_in(32'h190, 32'h0, 4'h0, 1'b1);
    step();
    check("ram_read", readData, memReadData);

    // LED byte lanes
    set_in(32'h0040_0000, 32'hAABB_CCDD, 4'b0101, 1'b0);
    #1 check("led_wmask_io", 32'(memWriteMask), 32'h0);
    step();
    check("led_lanes", LEDS, 32'h00BB_00DD);
    set_in(32'h0040_0000, 32'h0, 4'h0, 1'b1);
    step();
    check("led_read", readData, 32'h00BB_00DD);
    // Read on the same edge as a write returns the old value
    set_in(32'h0040_0000, 32'h1122_3344, 4'hF, 1'b1);
    step();
    check("led_read_old", readData, 32'h00BB_00DD);
    check("led_full", LEDS, 32'h1122_3344);

`ifdef MEMORY_IO_UART_EN
    // UART frame 0xA5
    set_in(32'h0040_0004, 32'h0000_00A5, 4'b0001, 1'b0);
    step();
    for (int i = 0; i < 40; i++) begin
      set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
      check("frame_bit", 32'(TXD), 32'(pat[i / 4]));
      step();
      check("frame_busy", readData, 32'h1);
    end
    check("frame_stop_idle", 32'(TXD), 32'h1);
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("frame_busy_fell", readData, 32'h0);

    // Overrun
    set_in(32'h0040_0004, 32'h0000_003C, 4'b0001, 1'b0);
    step();
    idle();
    steps(5);
    set_in(32'h0040_0004, 32'h0000_00FF, 4'b1111, 1'b0);
    step();
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("overrun_status", readData, 32'h3);
    idle();
    steps(40);
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("overrun_cleared", readData, 32'h0);

    // Back-to-back: write in the first idle cycle is accepted
    set_in(32'h0040_0004, 32'h0000_005A, 4'b0001, 1'b0);
    step();
    idle();
    steps(40);
    set_in(32'h0040_0004, 32'h0000_0077, 4'b0001, 1'b0);
    step();
    check("b2b_start", 32'(TXD), 32'h0);
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("b2b_no_overrun", readData, 32'h1);
    idle();
    steps(38);
    // Last stop cycle: still busy, so dropped
    set_in(32'h0040_0004, 32'h0000_0011, 4'b0001, 1'b0);
    step();
    check("last_stop_txd", 32'(TXD), 32'h1);
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("last_stop_drop", readData, 32'h2);
`else
    set_in(32'h0040_0004, 32'h0000_00A5, 4'b0001, 1'b0);
    step();
    check("no_uart_txd", 32'(TXD), 32'h1);
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("no_uart_status", readData, 32'h0);
`endif

    // Reset mid-frame
    set_in(32'h0040_0004, 32'h0000_00A5, 4'b0001, 1'b0);
    step();
    idle();
    steps(10);
    rst_n = 1'b0;
    #1;
    check("async_reset_txd", 32'(TXD), 32'h1);
    check("async_reset_leds", LEDS, 32'h0);
    step();
    rst_n = 1'b1;
    set_in(32'h0040_0008, 32'h0, 4'h0, 1'b1);
    step();
    check("reset_status", readData, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      a = $urandom;
      a[IoBit] = (r >= 40);
      m = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      set_in(a, $urandom, m, 1'($urandom_range(0, 1)));
      step();
      if (r == 99) begin
        #5;
        rst_n = 1'b0;
        #1;
        check("rand_reset_txd", 32'(TXD), 32'h1);
        check("rand_reset_leds", LEDS, 32'h0);
        step();
        rst_n = 1'b1;
      end
    end

    idle();
    steps(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
